// File: rtl/csr_commit_ctrl_if.sv
// Request/response bundle between writeback, the CSR file write port and the
// commit/difftest event port of csr_commit_ctrl.
interface csr_commit_ctrl_if #(
  parameter int XLEN = 32
);
  logic            inst_valid;
  logic            inst_ready;
  logic [11:0]     inst_waddr;
  logic [XLEN-1:0] inst_wdata;

  logic            exc_valid;
  logic            exc_ready;
  logic [XLEN-1:0] exc_cause;
  logic [XLEN-1:0] exc_pc;

  logic            mret_valid;
  logic            mret_ready;

  logic [XLEN-1:0] csr_mstatus;
  logic [XLEN-1:0] csr_mtvec;
  logic [XLEN-1:0] csr_mepc;

  logic            csr_wen;
  logic [11:0]     csr_waddr;
  logic [XLEN-1:0] csr_wdata;

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            busy;

  logic            commit_valid;
  logic            commit_csr_wen;
  logic            commit_exc;
  logic [11:0]     commit_waddr;
  logic [XLEN-1:0] commit_wdata;
  logic [XLEN-1:0] commit_mcause;
  logic [XLEN-1:0] commit_pc;

  // Requester / environment side
  modport master (
    output inst_valid, inst_waddr, inst_wdata,
    output exc_valid, exc_cause, exc_pc,
    output mret_valid,
    output csr_mstatus, csr_mtvec, csr_mepc,
    input  inst_ready, exc_ready, mret_ready,
    input  csr_wen, csr_waddr, csr_wdata,
    input  redirect_valid, redirect_pc, busy,
    input  commit_valid, commit_csr_wen, commit_exc,
    input  commit_waddr, commit_wdata, commit_mcause, commit_pc
  );

  // Controller side
  modport slave (
    input  inst_valid, inst_waddr, inst_wdata,
    input  exc_valid, exc_cause, exc_pc,
    input  mret_valid,
    input  csr_mstatus, csr_mtvec, csr_mepc,
    output inst_ready, exc_ready, mret_ready,
    output csr_wen, csr_waddr, csr_wdata,
    output redirect_valid, redirect_pc, busy,
    output commit_valid, commit_csr_wen, commit_exc,
    output commit_waddr, commit_wdata, commit_mcause, commit_pc
  );
endinterface

// File: rtl/csr_commit_ctrl.sv
// CSR write-port sequencer: serialises CSR-instruction writes, trap entry and
// mret into single-cycle CSR writes, issues the PC redirect and emits one
// registered commit event per completed operation.
//
// state          | meaning
// S_IDLE         | accepting requests (exc > mret > inst); inst writes complete here
// S_TRAP_MEPC    | writing mepc with the latched, word-aligned faulting pc
// S_TRAP_MCAUSE  | writing mcause with the latched cause
// S_TRAP_MSTATUS | writing trap-entry mstatus, redirecting to mtvec
// S_MRET_MSTATUS | writing mret mstatus, redirecting to mepc
module csr_commit_ctrl #(
  parameter int          XLEN         = 32,
  parameter logic [11:0] MSTATUS_ADDR = 12'h300,
  parameter logic [11:0] MEPC_ADDR    = 12'h341,
  parameter logic [11:0] MCAUSE_ADDR  = 12'h342
) (
  input  logic              clock,
  input  logic              reset,
  csr_commit_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRAP_MEPC,
    S_TRAP_MCAUSE,
    S_TRAP_MSTATUS,
    S_MRET_MSTATUS
  } state_t;

  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  state_t          r_state;
  logic            r_run;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_cause;

  logic            r_commit_valid;
  logic            r_commit_csr_wen;
  logic            r_commit_exc;
  logic [11:0]     r_commit_waddr;
  logic [XLEN-1:0] r_commit_wdata;
  logic [XLEN-1:0] r_commit_mcause;
  logic [XLEN-1:0] r_commit_pc;

  logic            w_ready;
  logic            w_exc_acc;
  logic            w_mret_acc;
  logic            w_inst_acc;
  logic [XLEN-1:0] w_mstatus_trap;
  logic [XLEN-1:0] w_mstatus_mret;

  // r_run keeps all readies low until the first clock edge after reset release
  assign w_ready    = r_run && (r_state == S_IDLE);
  assign w_exc_acc  = w_ready && bus.exc_valid;
  assign w_mret_acc = w_ready && !bus.exc_valid && bus.mret_valid;
  assign w_inst_acc = w_ready && !bus.exc_valid && !bus.mret_valid && bus.inst_valid;

  assign bus.exc_ready  = w_ready;
  assign bus.mret_ready = w_ready && !bus.exc_valid;
  assign bus.inst_ready = w_ready && !bus.exc_valid && !bus.mret_valid;
  assign bus.busy       = (r_state != S_IDLE);

  assign bus.commit_valid   = r_commit_valid;
  assign bus.commit_csr_wen = r_commit_csr_wen;
  assign bus.commit_exc     = r_commit_exc;
  assign bus.commit_waddr   = r_commit_waddr;
  assign bus.commit_wdata   = r_commit_wdata;
  assign bus.commit_mcause  = r_commit_mcause;
  assign bus.commit_pc      = r_commit_pc;

  // mstatus images for trap entry (MPIE<=MIE, MIE<=0) and mret (MIE<=MPIE, MPIE<=1); M-mode only
  always_comb begin
    w_mstatus_trap        = bus.csr_mstatus;
    w_mstatus_trap[7]     = bus.csr_mstatus[3];
    w_mstatus_trap[3]     = 1'b0;
    w_mstatus_trap[12:11] = 2'b11;
    w_mstatus_mret        = bus.csr_mstatus;
    w_mstatus_mret[3]     = bus.csr_mstatus[7];
    w_mstatus_mret[7]     = 1'b1;
    w_mstatus_mret[12:11] = 2'b11;
  end

  // CSR write port and redirect, decoded from state (inst writes pass straight through)
  always_comb begin
    bus.csr_wen        = 1'b0;
    bus.csr_waddr      = '0;
    bus.csr_wdata      = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    case (r_state)
      S_IDLE: begin
        if (w_inst_acc) begin
          bus.csr_wen   = 1'b1;
          bus.csr_waddr = bus.inst_waddr;
          bus.csr_wdata = bus.inst_wdata;
        end
      end
      S_TRAP_MEPC: begin
        bus.csr_wen   = 1'b1;
        bus.csr_waddr = MEPC_ADDR;
        bus.csr_wdata = r_pc & ALIGN_MASK;
      end
      S_TRAP_MCAUSE: begin
        bus.csr_wen   = 1'b1;
        bus.csr_waddr = MCAUSE_ADDR;
        bus.csr_wdata = r_cause;
      end
      S_TRAP_MSTATUS: begin
        bus.csr_wen        = 1'b1;
        bus.csr_waddr      = MSTATUS_ADDR;
        bus.csr_wdata      = w_mstatus_trap;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = bus.csr_mtvec & ALIGN_MASK;
      end
      S_MRET_MSTATUS: begin
        bus.csr_wen        = 1'b1;
        bus.csr_waddr      = MSTATUS_ADDR;
        bus.csr_wdata      = w_mstatus_mret;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = bus.csr_mepc;
      end
      default: ;
    endcase
  end

  // Sequencer state, trap latches and the registered commit event
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state          <= S_IDLE;
      r_run            <= 1'b0;
      r_pc             <= '0;
      r_cause          <= '0;
      r_commit_valid   <= 1'b0;
      r_commit_csr_wen <= 1'b0;
      r_commit_exc     <= 1'b0;
      r_commit_waddr   <= '0;
      r_commit_wdata   <= '0;
      r_commit_mcause  <= '0;
      r_commit_pc      <= '0;
    end else begin
      r_run          <= 1'b1;
      r_commit_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_exc_acc) begin
            r_pc    <= bus.exc_pc;
            r_cause <= bus.exc_cause;
            r_state <= S_TRAP_MEPC;
          end else if (w_mret_acc) begin
            r_state <= S_MRET_MSTATUS;
          end else if (w_inst_acc) begin
            r_commit_valid   <= 1'b1;
            r_commit_csr_wen <= 1'b1;
            r_commit_exc     <= 1'b0;
            r_commit_waddr   <= bus.inst_waddr;
            r_commit_wdata   <= bus.inst_wdata;
            r_commit_mcause  <= '0;
            r_commit_pc      <= '0;
          end
        end
        S_TRAP_MEPC:   r_state <= S_TRAP_MCAUSE;
        S_TRAP_MCAUSE: r_state <= S_TRAP_MSTATUS;
        S_TRAP_MSTATUS: begin
          r_commit_valid   <= 1'b1;
          r_commit_csr_wen <= 1'b0;
          r_commit_exc     <= 1'b1;
          r_commit_waddr   <= MSTATUS_ADDR;
          r_commit_wdata   <= w_mstatus_trap;
          r_commit_mcause  <= r_cause;
          r_commit_pc      <= r_pc;
          r_state          <= S_IDLE;
        end
        S_MRET_MSTATUS: begin
          r_commit_valid   <= 1'b1;
          r_commit_csr_wen <= 1'b0;
          r_commit_exc     <= 1'b0;
          r_commit_waddr   <= MSTATUS_ADDR;
          r_commit_wdata   <= w_mstatus_mret;
          r_commit_mcause  <= '0;
          r_commit_pc      <= bus.csr_mepc;
          r_state          <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_commit_ctrl.sv
// Directed bench for csr_commit_ctrl: expected CSR writes and commit events are
// queued as stimulus is driven and checked in order by a negedge monitor.
module tb_csr_commit_ctrl;
  localparam int XLEN = 32;

  logic clock = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  csr_commit_ctrl_if #(.XLEN(XLEN)) bus();

  csr_commit_ctrl #(.XLEN(XLEN)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
    logic        redir;
    logic [31:0] rpc;
  } wr_t;

  typedef struct {
    logic        cwen;
    logic        cexc;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic [31:0] mcause;
    logic [31:0] pc;
  } cm_t;

  wr_t wq[$];
  cm_t cq[$];
  wr_t ew;
  cm_t ec;

  logic [11:0] b2b_a [3] = '{12'h300, 12'h341, 12'hB00};
  logic [31:0] b2b_d [3] = '{32'h0000_1234, 32'hCAFE_0004, 32'h5A5A_A5A5};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard monitor: every CSR write and commit event must match the queue head
  always @(negedge clock) begin
    if (bus.csr_wen === 1'b1) begin
      chk("wr_expected", 32'(wq.size() != 0), 32'd1);
      if (wq.size() != 0) begin
        ew = wq.pop_front();
        chk("wr_addr", 32'(bus.csr_waddr), 32'(ew.addr));
        chk("wr_data", bus.csr_wdata, ew.data);
        chk("wr_redirect", 32'(bus.redirect_valid), 32'(ew.redir));
        if (ew.redir) chk("wr_redirect_pc", bus.redirect_pc, ew.rpc);
      end
    end else begin
      chk("redirect_without_write", 32'(bus.redirect_valid), 32'd0);
    end
    if (bus.commit_valid === 1'b1) begin
      chk("cm_expected", 32'(cq.size() != 0), 32'd1);
      if (cq.size() != 0) begin
        ec = cq.pop_front();
        chk("cm_csr_wen", 32'(bus.commit_csr_wen), 32'(ec.cwen));
        chk("cm_exc", 32'(bus.commit_exc), 32'(ec.cexc));
        chk("cm_pc", bus.commit_pc, ec.pc);
        if (ec.cwen) begin
          chk("cm_waddr", 32'(bus.commit_waddr), 32'(ec.waddr));
          chk("cm_wdata", bus.commit_wdata, ec.wdata);
        end
        if (ec.cexc) chk("cm_mcause", bus.commit_mcause, ec.mcause);
      end
    end
  end

  initial begin
    // Reset with every request asserted
    reset           = 1'b0;
    bus.inst_valid  = 1'b1;
    bus.exc_valid   = 1'b1;
    bus.mret_valid  = 1'b1;
    bus.inst_waddr  = 12'h305;
    bus.inst_wdata  = 32'h1111_1111;
    bus.exc_cause   = 32'd2;
    bus.exc_pc      = 32'h8000_0000;
    bus.csr_mstatus = 32'h0000_0008;
    bus.csr_mtvec   = 32'h8000_0201;
    bus.csr_mepc    = 32'h8000_0014;
    repeat (2) @(negedge clock);
    chk("rst_exc_ready", 32'(bus.exc_ready), 32'd0);
    chk("rst_mret_ready", 32'(bus.mret_ready), 32'd0);
    chk("rst_inst_ready", 32'(bus.inst_ready), 32'd0);
    chk("rst_csr_wen", 32'(bus.csr_wen), 32'd0);
    chk("rst_csr_waddr", 32'(bus.csr_waddr), 32'd0);
    chk("rst_csr_wdata", bus.csr_wdata, 32'd0);
    chk("rst_redirect_valid", 32'(bus.redirect_valid), 32'd0);
    chk("rst_redirect_pc", bus.redirect_pc, 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_commit_valid", 32'(bus.commit_valid), 32'd0);
    chk("rst_commit_csr_wen", 32'(bus.commit_csr_wen), 32'd0);
    chk("rst_commit_exc", 32'(bus.commit_exc), 32'd0);
    chk("rst_commit_waddr", 32'(bus.commit_waddr), 32'd0);
    chk("rst_commit_wdata", bus.commit_wdata, 32'd0);
    chk("rst_commit_mcause", bus.commit_mcause, 32'd0);
    chk("rst_commit_pc", bus.commit_pc, 32'd0);

    // Release: readies come up on the following cycle
    tick();
    bus.inst_valid = 1'b0;
    bus.exc_valid  = 1'b0;
    bus.mret_valid = 1'b0;
    reset          = 1'b1;
    #1;
    chk("rel_exc_ready_same_cycle", 32'(bus.exc_ready), 32'd0);
    tick();
    @(negedge clock);
    chk("rel_exc_ready", 32'(bus.exc_ready), 32'd1);

    // Single inst write 0x305 <= 0x8000_0100
    tick();
    bus.inst_valid = 1'b1;
    bus.inst_waddr = 12'h305;
    bus.inst_wdata = 32'h8000_0100;
    wq.push_back('{12'h305, 32'h8000_0100, 1'b0, 32'h0});
    cq.push_back('{1'b1, 1'b0, 12'h305, 32'h8000_0100, 32'h0, 32'h0});
    @(negedge clock);
    chk("inst_ready", 32'(bus.inst_ready), 32'd1);
    chk("inst_wen_same_cycle", 32'(bus.csr_wen), 32'd1);
    chk("inst_no_commit_yet", 32'(bus.commit_valid), 32'd0);
    tick();
    bus.inst_valid = 1'b0;
    @(negedge clock);
    chk("inst_commit_t1", 32'(bus.commit_valid), 32'd1);
    chk("inst_wen_drop", 32'(bus.csr_wen), 32'd0);

    // Three back-to-back inst writes
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i < 3) begin
        bus.inst_valid = 1'b1;
        bus.inst_waddr = b2b_a[i];
        bus.inst_wdata = b2b_d[i];
        wq.push_back('{b2b_a[i], b2b_d[i], 1'b0, 32'h0});
        cq.push_back('{1'b1, 1'b0, b2b_a[i], b2b_d[i], 32'h0, 32'h0});
      end else begin
        bus.inst_valid = 1'b0;
      end
      @(negedge clock);
      if (i < 3) chk("b2b_wen", 32'(bus.csr_wen), 32'd1);
      if (i > 0) chk("b2b_commit", 32'(bus.commit_valid), 32'd1);
    end
    tick();
    @(negedge clock);
    chk("b2b_commit_end", 32'(bus.commit_valid), 32'd0);
    chk("hold_commit_waddr", 32'(bus.commit_waddr), 32'h0000_0B00);
    chk("hold_commit_wdata", bus.commit_wdata, 32'h5A5A_A5A5);

    // Trap entry
    bus.csr_mstatus = 32'h0000_0008;
    bus.csr_mtvec   = 32'h8000_0201;
    tick();
    bus.exc_valid = 1'b1;
    bus.exc_pc    = 32'h8000_0012;
    bus.exc_cause = 32'd11;
    wq.push_back('{12'h341, 32'h8000_0010, 1'b0, 32'h0});
    wq.push_back('{12'h342, 32'd11, 1'b0, 32'h0});
    wq.push_back('{12'h300, 32'h0000_1880, 1'b1, 32'h8000_0200});
    cq.push_back('{1'b0, 1'b1, 12'h300, 32'h0, 32'd11, 32'h8000_0012});
    @(negedge clock);
    chk("trap_exc_ready", 32'(bus.exc_ready), 32'd1);
    chk("trap_t0_no_write", 32'(bus.csr_wen), 32'd0);
    chk("trap_t0_busy", 32'(bus.busy), 32'd0);
    tick();
    bus.exc_valid = 1'b0;
    bus.exc_pc    = 32'hFFFF_FFFF;
    bus.exc_cause = 32'hFFFF_FFFF;
    @(negedge clock);
    chk("trap_t1_busy", 32'(bus.busy), 32'd1);
    chk("trap_t1_addr", 32'(bus.csr_waddr), 32'h341);
    tick();
    @(negedge clock);
    chk("trap_t2_addr", 32'(bus.csr_waddr), 32'h342);
    chk("trap_t2_exc_ready", 32'(bus.exc_ready), 32'd0);
    tick();
    @(negedge clock);
    chk("trap_t3_addr", 32'(bus.csr_waddr), 32'h300);
    chk("trap_t3_redirect", 32'(bus.redirect_valid), 32'd1);
    tick();
    @(negedge clock);
    chk("trap_t4_commit", 32'(bus.commit_valid), 32'd1);
    chk("trap_t4_busy", 32'(bus.busy), 32'd0);
    chk("trap_t4_exc_ready", 32'(bus.exc_ready), 32'd1);

    // mret
    bus.csr_mstatus = 32'h0000_1880;
    bus.csr_mepc    = 32'h8000_0014;
    tick();
    bus.mret_valid = 1'b1;
    wq.push_back('{12'h300, 32'h0000_1888, 1'b1, 32'h8000_0014});
    cq.push_back('{1'b0, 1'b0, 12'h300, 32'h0, 32'h0, 32'h8000_0014});
    @(negedge clock);
    chk("mret_ready", 32'(bus.mret_ready), 32'd1);
    chk("mret_t0_no_write", 32'(bus.csr_wen), 32'd0);
    tick();
    bus.mret_valid = 1'b0;
    @(negedge clock);
    chk("mret_t1_wen", 32'(bus.csr_wen), 32'd1);
    chk("mret_t1_busy", 32'(bus.busy), 32'd1);
    tick();
    @(negedge clock);
    chk("mret_t2_commit", 32'(bus.commit_valid), 32'd1);
    chk("mret_t2_busy", 32'(bus.busy), 32'd0);

    // Simultaneous exc + mret + inst: exc, then mret, then inst
    bus.csr_mstatus = 32'h0000_0002;
    bus.csr_mtvec   = 32'h8000_0401;
    bus.csr_mepc    = 32'h8000_0020;
    tick();
    bus.exc_valid  = 1'b1;
    bus.mret_valid = 1'b1;
    bus.inst_valid = 1'b1;
    bus.exc_pc     = 32'h8000_0030;
    bus.exc_cause  = 32'd7;
    bus.inst_waddr = 12'h340;
    bus.inst_wdata = 32'h0000_DEAD;
    wq.push_back('{12'h341, 32'h8000_0030, 1'b0, 32'h0});
    wq.push_back('{12'h342, 32'd7, 1'b0, 32'h0});
    wq.push_back('{12'h300, 32'h0000_1802, 1'b1, 32'h8000_0400});
    cq.push_back('{1'b0, 1'b1, 12'h300, 32'h0, 32'd7, 32'h8000_0030});
    wq.push_back('{12'h300, 32'h0000_1888, 1'b1, 32'h8000_0020});
    cq.push_back('{1'b0, 1'b0, 12'h300, 32'h0, 32'h0, 32'h8000_0020});
    wq.push_back('{12'h340, 32'h0000_DEAD, 1'b0, 32'h0});
    cq.push_back('{1'b1, 1'b0, 12'h340, 32'h0000_DEAD, 32'h0, 32'h0});
    @(negedge clock);
    chk("sim_exc_ready", 32'(bus.exc_ready), 32'd1);
    chk("sim_mret_ready", 32'(bus.mret_ready), 32'd0);
    chk("sim_inst_ready", 32'(bus.inst_ready), 32'd0);
    chk("sim_no_inst_write", 32'(bus.csr_wen), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 0) bus.exc_valid = 1'b0;
      @(negedge clock);
      chk("sim_trap_mret_ready", 32'(bus.mret_ready), 32'd0);
      chk("sim_trap_inst_ready", 32'(bus.inst_ready), 32'd0);
    end
    tick();
    bus.csr_mstatus = 32'h0000_0080;
    @(negedge clock);
    chk("sim_trap_commit", 32'(bus.commit_valid), 32'd1);
    chk("sim_mret_ready_idle", 32'(bus.mret_ready), 32'd1);
    chk("sim_inst_ready_blocked", 32'(bus.inst_ready), 32'd0);
    tick();
    bus.mret_valid = 1'b0;
    @(negedge clock);
    chk("sim_mret_busy", 32'(bus.busy), 32'd1);
    chk("sim_mret_inst_ready", 32'(bus.inst_ready), 32'd0);
    tick();
    @(negedge clock);
    chk("sim_inst_ready_last", 32'(bus.inst_ready), 32'd1);
    chk("sim_inst_wen", 32'(bus.csr_wen), 32'd1);
    tick();
    bus.inst_valid = 1'b0;
    @(negedge clock);
    chk("sim_inst_commit", 32'(bus.commit_valid), 32'd1);

    // Reset asserted while in TRAP_MCAUSE abandons the trap
    tick();
    bus.exc_valid = 1'b1;
    bus.exc_pc    = 32'h8000_0043;
    bus.exc_cause = 32'd5;
    wq.push_back('{12'h341, 32'h8000_0040, 1'b0, 32'h0});
    @(negedge clock);
    chk("rm_exc_ready", 32'(bus.exc_ready), 32'd1);
    tick();
    bus.exc_valid = 1'b0;
    @(negedge clock);
    chk("rm_mepc_addr", 32'(bus.csr_waddr), 32'h341);
    tick();
    reset = 1'b0;
    #1;
    chk("rm_busy", 32'(bus.busy), 32'd0);
    chk("rm_wen", 32'(bus.csr_wen), 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      chk("rm_hold_wen", 32'(bus.csr_wen), 32'd0);
      chk("rm_hold_redirect", 32'(bus.redirect_valid), 32'd0);
      chk("rm_hold_commit", 32'(bus.commit_valid), 32'd0);
    end
    chk("rm_commit_pc_cleared", bus.commit_pc, 32'd0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("rm_post_commit", 32'(bus.commit_valid), 32'd0);
      chk("rm_post_redirect", 32'(bus.redirect_valid), 32'd0);
      chk("rm_post_busy", 32'(bus.busy), 32'd0);
    end

    chk("wr_queue_drained", 32'(wq.size()), 32'd0);
    chk("cm_queue_drained", 32'(cq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
